// File: rtl/envio_serial_pkg.sv
// Shared definitions for the multichannel serial dump engine: FSM encoding,
// end-of-frame marker, default channel tags and width helpers.
package envio_serial_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECIONA,
        S_LE,
        S_CARREGA,
        S_ENVIA,
        S_ESPERA,
        S_PROXIMO,
        S_FIM_QUADRO,
        S_FIM
    } estado_t;

    localparam logic [31:0] FIM_QUADRO  = '1;
    localparam logic [1:0]  TAGS_PADRAO = 2'b10;

    function automatic int clog2(input int valor);
        int r;
        r = 0;
        while ((1 << r) < valor) r++;
        return r;
    endfunction

    // Never returns zero so every port keeps at least one bit.
    function automatic int largura(input int valor);
        return (clog2(valor) < 1) ? 1 : clog2(valor);
    endfunction

endpackage

// File: rtl/envio_serial_multicanal_contador_m.sv
// contador_m: modulo-M up counter with synchronous clear, used as the
// per-channel read address of the dump engine.
module contador_m
    import envio_serial_pkg::*;
#(
    parameter int M = 15,
    parameter int N = 4
)(
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] Q
);

    localparam logic [N-1:0] ULTIMO = N'(M - 1);

    logic [N-1:0] r_q;

    always_ff @(posedge clock) begin
        if (!reset || zera_s) begin
            r_q <= '0;
        end else if (conta) begin
            r_q <= (r_q == ULTIMO) ? '0 : r_q + 1'b1;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/envio_serial_multicanal.sv
// envio_serial_multicanal: scans NUM_CH memories and feeds tagged words to the
// 7O1 transmitter. Define ENVIO_SERIAL_FIM_QUADRO_EN to append an all-ones marker.
module envio_serial_multicanal
    import envio_serial_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 15,
    parameter int PAYLOAD_W = 6,
    parameter int WORD_W    = 7,
    parameter logic [NUM_CH*(WORD_W-PAYLOAD_W)-1:0] TAGS = TAGS_PADRAO
)(
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   inicio,
    input  logic                                   aborta,
    input  logic [NUM_CH*ADDR_W-1:0]               comprimentos,
    output logic [largura(NUM_CH)-1:0]             rd_ch,
    output logic [ADDR_W-1:0]                      rd_addr,
    input  logic [PAYLOAD_W-1:0]                   rd_data,
    output logic                                   tx_partida,
    output logic [WORD_W-1:0]                      tx_dados,
    input  logic                                   tx_pronto,
    output logic                                   ocupado,
    output logic                                   fim,
    output logic                                   abortado,
    output logic [largura(NUM_CH*DEPTH+2)-1:0]     enviados
);

    localparam int TAG_W = WORD_W - PAYLOAD_W;
    localparam int LEN_W = ADDR_W + 1;
    localparam int CH_W  = largura(NUM_CH);
    localparam int CHX_W = largura(NUM_CH + 1);
    localparam int ENV_W = largura(NUM_CH*DEPTH+2);

    localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH);
    localparam logic [CHX_W-1:0] NUM_CH_L  = CHX_W'(NUM_CH);
    localparam logic [CHX_W-1:0] ULTIMO_CH = CHX_W'(NUM_CH - 1);

    estado_t           r_estado;
    logic [CHX_W-1:0]  r_ch;
    logic [LEN_W-1:0]  r_len [NUM_CH];
    logic [WORD_W-1:0] r_tx_dados;
    logic [ENV_W-1:0]  r_enviados;
    logic              r_partida;
    logic              r_ocupado;
    logic              r_fim;
    logic              r_abortado;
`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
    logic              r_marcador;
`endif

    logic [LEN_W-1:0]  w_len_clamp [NUM_CH];
    logic [LEN_W-1:0]  w_len_atual;
    logic [TAG_W-1:0]  w_tag;
    logic [ADDR_W-1:0] w_addr;
    logic              w_passou;
    logic              w_fim_canal;
    logic              w_avanca_sel;
    logic              w_avanca_prox;
    logic              w_conta;
    logic              w_zera;

    always_comb begin
        w_len_atual = '0;
        w_tag       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_len_clamp[i] = ({1'b0, comprimentos[i*ADDR_W +: ADDR_W]} > DEPTH_L)
                           ? DEPTH_L : {1'b0, comprimentos[i*ADDR_W +: ADDR_W]};
            if (r_ch == CHX_W'(i)) begin
                w_len_atual = r_len[i];
                w_tag       = TAGS[i*TAG_W +: TAG_W];
            end
        end
    end

    // r_ch reaches NUM_CH after the last channel; that is the "past the end" marker.
    assign w_passou      = (r_ch >= NUM_CH_L);
    assign w_fim_canal   = (({1'b0, w_addr} + 1'b1) == w_len_atual);
    assign w_avanca_sel  = (r_estado == S_SELECIONA) && !w_passou && (w_len_atual == '0);
    assign w_avanca_prox = (r_estado == S_PROXIMO) && !aborta && w_fim_canal;
    assign w_conta       = (r_estado == S_PROXIMO) && !aborta && !w_fim_canal;
    assign w_zera        = w_avanca_sel || w_avanca_prox || ((r_estado == S_IDLE) && inicio);

    contador_m #(
        .M(DEPTH),
        .N(ADDR_W)
    ) u_contador (
        .clock  (clock),
        .reset  (reset),
        .zera_s (w_zera),
        .conta  (w_conta),
        .Q      (w_addr)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado   <= S_IDLE;
            r_ch       <= '0;
            r_tx_dados <= '0;
            r_enviados <= '0;
            r_partida  <= 1'b0;
            r_ocupado  <= 1'b0;
            r_fim      <= 1'b0;
            r_abortado <= 1'b0;
`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
            r_marcador <= 1'b0;
`endif
            for (int unsigned i = 0; i < NUM_CH; i++) r_len[i] <= '0;
        end else begin
            r_partida <= 1'b0;
            r_fim     <= 1'b0;
            case (r_estado)
                S_IDLE: begin
                    if (inicio) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) r_len[i] <= w_len_clamp[i];
                        r_ch       <= '0;
                        r_enviados <= '0;
                        r_abortado <= 1'b0;
                        r_ocupado  <= 1'b1;
`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
                        r_marcador <= 1'b0;
`endif
                        r_estado   <= S_SELECIONA;
                    end
                end
                S_SELECIONA: begin
                    if (!w_passou && (w_len_atual != '0)) begin
                        r_estado <= S_LE;
                    end else begin
                        if (!w_passou) r_ch <= r_ch + 1'b1;
                        // An empty last channel ends the scan in the same cycle it is skipped.
                        if (w_passou || (r_ch == ULTIMO_CH)) begin
`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
                            r_estado  <= S_FIM_QUADRO;
`else
                            r_estado  <= S_FIM;
                            r_fim     <= 1'b1;
                            r_ocupado <= 1'b0;
`endif
                        end
                    end
                end
                S_LE: begin
                    r_estado <= S_CARREGA;
                end
                S_CARREGA: begin
                    r_tx_dados <= {w_tag, rd_data};
                    r_partida  <= 1'b1;
                    r_estado   <= S_ENVIA;
                end
`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
                S_FIM_QUADRO: begin
                    r_tx_dados <= FIM_QUADRO[WORD_W-1:0];
                    r_marcador <= 1'b1;
                    r_partida  <= 1'b1;
                    r_estado   <= S_ENVIA;
                end
`endif
                S_ENVIA: begin
                    r_estado <= S_ESPERA;
                end
                S_ESPERA: begin
                    if (tx_pronto) begin
                        r_enviados <= r_enviados + 1'b1;
`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
                        if (r_marcador) begin
                            r_estado  <= S_FIM;
                            r_fim     <= 1'b1;
                            r_ocupado <= 1'b0;
                        end else begin
                            r_estado  <= S_PROXIMO;
                        end
`else
                        r_estado   <= S_PROXIMO;
`endif
                    end
                end
                S_PROXIMO: begin
                    if (aborta) begin
                        r_abortado <= 1'b1;
                        r_estado   <= S_FIM;
                        r_fim      <= 1'b1;
                        r_ocupado  <= 1'b0;
                    end else if (w_fim_canal) begin
                        r_ch     <= r_ch + 1'b1;
                        r_estado <= S_SELECIONA;
                    end else begin
                        r_estado <= S_LE;
                    end
                end
                S_FIM: begin
                    r_estado <= S_IDLE;
                end
                default: begin
                    r_estado <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_ch      = r_ch[CH_W-1:0];
    assign rd_addr    = w_addr;
    assign tx_partida = r_partida;
    assign tx_dados   = r_tx_dados;
    assign ocupado    = r_ocupado;
    assign fim        = r_fim;
    assign abortado   = r_abortado;
    assign enviados   = r_enviados;

endmodule

// File: tb/tb_envio_serial_multicanal.sv
// Directed bench for envio_serial_multicanal (DEPTH=12 so the length clamp is exercised).
module tb_envio_serial_multicanal;

`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
    localparam int MARC = 1;
`else
    localparam int MARC = 0;
`endif

    logic       clock;
    logic       reset;
    logic       inicio;
    logic       aborta;
    logic [7:0] comprimentos;
    logic [0:0] rd_ch;
    logic [3:0] rd_addr;
    logic [5:0] rd_data;
    logic       tx_partida;
    logic [6:0] tx_dados;
    logic       tx_pronto;
    logic       ocupado;
    logic       fim;
    logic       abortado;
    logic [4:0] enviados;

    envio_serial_multicanal #(
        .DEPTH(12)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .inicio       (inicio),
        .aborta       (aborta),
        .comprimentos (comprimentos),
        .rd_ch        (rd_ch),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .tx_partida   (tx_partida),
        .tx_dados     (tx_dados),
        .tx_pronto    (tx_pronto),
        .ocupado      (ocupado),
        .fim          (fim),
        .abortado     (abortado),
        .enviados     (enviados)
    );

    int n_testes = 0;
    int n_falhas = 0;
    int cyc = 0;

    logic [5:0] mem [2][16];
    logic [6:0] palavras [64];
    int         pcyc [64];
    int         nw = 0;
    int         pend = 0;
    int         nfim = 0;
    int         fim_cyc = 0;
    int         fim_env = 0;
    int         fim_abt = 0;
    int         fim_ocp = 0;
    int         max_addr = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) rd_data <= mem[rd_ch][rd_addr];

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    // Transmitter stand-in: answers every partida with tx_pronto 5 cycles later.
    initial begin
        forever begin
            @(negedge clock);
            if (tx_pronto) tx_pronto = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) tx_pronto = 1'b1;
            end
            if (tx_partida === 1'b1) begin
                palavras[nw] = tx_dados;
                pcyc[nw]     = cyc;
                if (nw < 63) nw++;
                pend = 5;
            end
            if (ocupado === 1'b1 && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            if (fim === 1'b1) begin
                nfim++;
                fim_cyc = cyc;
                fim_env = int'(enviados);
                fim_abt = int'(abortado);
                fim_ocp = int'(ocupado);
            end
        end
    end

    task automatic dispara(input logic [3:0] l0, input logic [3:0] l1, output int t);
        repeat (2) @(negedge clock);
        nw       = 0;
        nfim     = 0;
        max_addr = 0;
        comprimentos = {l1, l0};
        inicio = 1'b1;
        t = cyc;
        @(negedge clock);
        inicio = 1'b0;
    endtask

    task automatic espera_fim(input int maxc);
        int n;
        n = 0;
        while (nfim == 0 && n < maxc) begin
            @(negedge clock);
            n++;
        end
        verifica("fim_timeout", (nfim != 0), 1);
    endtask

    task automatic espera_palavras(input int alvo, input int maxc);
        int n;
        n = 0;
        while (nw < alvo && n < maxc) begin
            @(negedge clock);
            n++;
        end
        verifica("partida_timeout", (nw >= alvo), 1);
    endtask

    initial begin
        int t;
        #100000;
        $display("FAIL watchdog: obtido=timeout esperado=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = 6'(5 + 7*i);
            mem[1][i] = 6'h2A ^ 6'(i);
        end
        reset = 1'b0;
        inicio = 1'b0;
        aborta = 1'b0;
        comprimentos = '0;
        tx_pronto = 1'b0;
        repeat (3) @(negedge clock);
        verifica("reset", {tx_partida, tx_dados, rd_ch, rd_addr, ocupado, fim, abortado, enviados}, 0);
        reset = 1'b1;

        // Basic two-channel dump
        dispara(4'd3, 4'd2, t);
        verifica("b_ocupado_t1", ocupado, 1);
        espera_fim(300);
        verifica("b_nw", nw, 5 + MARC);
        for (int i = 0; i < 3; i++) verifica("b_w_ch0", palavras[i], {1'b0, mem[0][i]});
        for (int i = 0; i < 2; i++) verifica("b_w_ch1", palavras[3+i], {1'b1, mem[1][i]});
        verifica("b_primeira_partida", pcyc[0] - t, 4);
        verifica("b_intervalo", pcyc[1] - pcyc[0], 9);
        verifica("b_enviados", fim_env, 5 + MARC);
        verifica("b_abortado", fim_abt, 0);
        verifica("b_ocupado_fim", fim_ocp, 0);
`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
        verifica("b_marcador", palavras[5], 7'h7F);
        verifica("b_fim_ciclo", fim_cyc - pcyc[5], 6);
`else
        verifica("b_fim_ciclo", fim_cyc - pcyc[4], 8);
`endif

        // Empty channel 0 skipped
        dispara(4'd0, 4'd1, t);
        repeat (2) @(negedge clock);
        verifica("e_rd_ch_t3", {rd_ch, rd_addr}, {1'b1, 4'd0});
        espera_fim(200);
        verifica("e_nw", nw, 1 + MARC);
        verifica("e_w", palavras[0], {1'b1, mem[1][0]});
        verifica("e_primeira_partida", pcyc[0] - t, 5);
        verifica("e_enviados", fim_env, 1 + MARC);

        // Length 15 clamped to DEPTH=12
        dispara(4'd15, 4'd0, t);
        espera_fim(500);
        verifica("c_nw", nw, 12 + MARC);
        for (int i = 0; i < 12; i++) verifica("c_w", palavras[i], {1'b0, mem[0][i]});
        verifica("c_max_addr", max_addr, 11);
        verifica("c_enviados", fim_env, 12 + MARC);

        // Abort during word 1
        dispara(4'd4, 4'd0, t);
        espera_palavras(2, 100);
        aborta = 1'b1;
        espera_fim(100);
        aborta = 1'b0;
        repeat (3) @(negedge clock);
        verifica("a_nw", nw, 2);
        verifica("a_w1", palavras[1], {1'b0, mem[0][1]});
        verifica("a_abortado_fim", fim_abt, 1);
        verifica("a_enviados", fim_env, 2);
        verifica("a_abortado_mantido", abortado, 1);

        // Ignored restart, then reset in ESPERA
        dispara(4'd3, 4'd2, t);
        verifica("r_abortado_limpo", abortado, 0);
        @(negedge clock);
        inicio = 1'b1;
        @(negedge clock);
        inicio = 1'b0;
        espera_palavras(2, 100);
        repeat (2) @(negedge clock);
        verifica("r_w1", palavras[1], {1'b0, mem[0][1]});
        verifica("r_partida1", pcyc[1] - t, 13);
        verifica("r_enviados_meio", enviados, 1);
        reset = 1'b0;
        pend = 0;
        tx_pronto = 1'b0;
        @(negedge clock);
        verifica("r_reset_meio", {tx_partida, tx_dados, rd_ch, rd_addr, ocupado, fim, abortado, enviados}, 0);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        verifica("r_sem_partida", nw, 2);
        verifica("r_ocioso", ocupado, 0);

        // All lengths zero
        dispara(4'd0, 4'd0, t);
        espera_fim(100);
`ifdef ENVIO_SERIAL_FIM_QUADRO_EN
        verifica("z_nw", nw, 1);
        verifica("z_marcador", palavras[0], 7'h7F);
        verifica("z_enviados", fim_env, 1);
`else
        verifica("z_nw", nw, 0);
        verifica("z_fim_ciclo", fim_cyc - t, 3);
        verifica("z_enviados", fim_env, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule

// File: doc/envio_serial_multicanal.md
# envio_serial_multicanal

Parametrised automatic serial dump engine for SmartCargo. It scans `NUM_CH` word memories, such as elevator queue and elevator contents, reading a run-time number of entries from each one. Each entry is prefixed with a per-channel tag and handed to the existing 7O1 UART transmitter through a partida/pronto handshake. The block carries its own control FSM and sits between the cargo memories and `tx_serial_7O1`.

## Interface
- `NUM_CH`, 2: number of source memories/channels.
- `ADDR_W`, 4: memory address width.
- `DEPTH`, 15: maximum entries per channel, at most 2^ADDR_W.
- `PAYLOAD_W`, 6: payload bits read from memory.
- `WORD_W`, 7: transmitted word width; `TAG_W = WORD_W - PAYLOAD_W`, at least 1.
- `TAGS`, {1'b1, 1'b0}: packed `NUM_CH*TAG_W` tags; channel i uses slice i.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `inicio` in 1: start request, sampled only in IDLE.
- `aborta` in 1: level; stop after the current word.
- `comprimentos` in `NUM_CH*ADDR_W`: entries to send per channel; slice i belongs to channel i.
- `rd_ch` out clog2(`NUM_CH`): channel/memory select.
- `rd_addr` out `ADDR_W`: read address.
- `rd_data` in `PAYLOAD_W`: memory data; valid 1 cycle after `rd_ch`/`rd_addr`.
- `tx_partida` out 1: one-cycle start pulse to the transmitter.
- `tx_dados` out `WORD_W`: word to transmit.
- `tx_pronto` in 1: one-cycle transmitter-done pulse.
- `ocupado` out 1: dump in progress.
- `fim` out 1: one-cycle completion pulse.
- `abortado` out 1: last dump ended by `aborta`; held until the next `inicio`.
- `enviados` out clog2(`NUM_CH*DEPTH+2`): words sent in the current/last dump.

## Operation
- FSM states: IDLE, SELECIONA, LE, CARREGA, ENVIA, ESPERA, PROXIMO, FIM_QUADRO (macro only), FIM.
- IDLE:
  - On `inicio`=1, snapshot `comprimentos`, clamping each value to `DEPTH`.
  - Clear `enviados` and `abortado`, set channel=0 and addr=0, go to SELECIONA.
- SELECIONA:
  - If the current channel length is 0, advance the channel, one channel per cycle.
  - Past the last channel, go to FIM_QUADRO if compiled in, else FIM.
  - Otherwise go to LE.
- LE: drive `rd_ch`/`rd_addr`.
- CARREGA: `tx_dados <= {TAGS[ch], rd_data}`.
- ENVIA: `tx_partida`=1 for exactly one cycle.
- ESPERA: hold `tx_dados` stable; on `tx_pronto`, increment `enviados` and go to PROXIMO.
- PROXIMO:
  - If `aborta`, set `abortado`=1 and go to FIM.
  - Else if addr = len-1, set addr=0, advance the channel, go to SELECIONA.
  - Else addr+1, go to LE.
- FIM: `fim`=1, `ocupado`=0, go to IDLE.
- Boundary and abort rules:
  - `inicio` outside IDLE is ignored.
  - `aborta` never truncates a character in flight.
  - `aborta` in IDLE has no effect.
  - The address never wraps; the clamp guarantees addr ≤ `DEPTH`-1.
  - `tx_pronto` outside ESPERA is ignored.

## Timing
- `inicio` high in cycle t:
  - `ocupado` is 1 from t+1.
  - First `rd_addr` valid at t+2, if channel 0 is non-empty.
  - First `tx_partida` at t+4.
  - Each skipped empty channel adds 1 cycle.
- Between words: `tx_pronto` at cycle p gives the next `tx_partida` at p+4.
- All lengths zero, no macro: `fim` at t+NUM_CH+1.
- Reset values: every output is 0, including `tx_dados`, `rd_ch`, `rd_addr`, `abortado` and `enviados`; FSM in IDLE.
- `reset` asserted mid-dump: everything is back at reset values on the next edge; no further `tx_partida`.

## Configuration
- `ENVIO_SERIAL_FIM_QUADRO_EN` defined:
  - After the last channel, FIM_QUADRO sends one extra word, the all-ones marker `{WORD_W{1'b1}}`, with the same ENVIA/ESPERA handshake.
  - The marker counts in `enviados`.
  - The marker is skipped when `abortado` is set.
- Undefined: SELECIONA past the last channel goes directly to FIM.

## Structure
- Package `envio_serial_pkg`:
  - FSM state enum.
  - `FIM_QUADRO` marker constant.
  - Default `TAGS` value.
  - clog2 helper for the `enviados` width.
- Natural sub-module: `contador_m` (M=`DEPTH`, N=`ADDR_W`) for the address counter.
  - Its `zera_s` is driven by channel advance or by `inicio` in IDLE.
  - Its `conta` is driven by the PROXIMO no-wrap case.

## Test plan
- Basic two-channel dump:
  - Stimulus: defaults, len0=3, len1=2, `tx_pronto` 5 cycles after each partida.
  - Required response, words in order: {0,m0[0]}, {0,m0[1]}, {0,m0[2]}, {1,m1[0]}, {1,m1[1]}; then `fim`, `enviados`=5, first partida at t+4.
- Empty channel skipped:
  - Stimulus: len0=0, len1=1.
  - Required response: exactly one word, {1,m1[0]}; `rd_ch` never reads channel 0.
- Length clamp:
  - Stimulus: len0 input 15 with `DEPTH`=12.
  - Required response: 12 words; `rd_addr` runs 0..11 with no wrap.
- Abort mid-dump:
  - Stimulus: `aborta` raised during word 1 of len0=4.
  - Required response: word 1 completes, no further `tx_partida`, `fim` with `abortado`=1 and `enviados`=2.
- Ignored start, then reset mid-dump:
  - Stimulus: `inicio` re-pulsed while `ocupado`, then `reset`=0 during ESPERA.
  - Required response: the re-pulse has no effect; after reset all outputs are 0 and IDLE is reached next cycle.
- End-of-frame marker:
  - Stimulus: all lengths 0.
  - Required response with `ENVIO_SERIAL_FIM_QUADRO_EN`: a single word 7'h7F, `enviados`=1.
  - Required response without it: `fim` at t+3, no partida.
